// File: rtl/mmio_timer_pkg.sv
// ============================================================================
// Module : mmio_timer_pkg
// Brief  : Register offsets, CTRL bit indices and FSM encoding for mmio_timer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mmio_timer_pkg;

    // Word offsets, compared against memaddr[4:2]
    localparam logic [2:0] TMR_CTRL   = 3'd0;
    localparam logic [2:0] TMR_LOAD   = 3'd1;
    localparam logic [2:0] TMR_COUNT  = 3'd2;
    localparam logic [2:0] TMR_STATUS = 3'd3;
    localparam logic [2:0] TMR_PRESC  = 3'd4;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } tmr_state_t;

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ============================================================================
// Module : timer_prescaler
// Brief  : Free-running divider; emits a one-cycle tick every PRESC+1 cycles.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module timer_prescaler #(
    parameter int PRESC_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_run,
    input  logic               i_clr,
    input  logic [PRESC_W-1:0] i_presc,
    output logic               o_tick
);

    logic [PRESC_W-1:0] r_cnt;

    assign o_tick = i_run && (r_cnt == i_presc);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= o_tick ? '0 : r_cnt + {{(PRESC_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

`default_nettype wire

// File: rtl/mmio_timer.sv
// ============================================================================
// Module : mmio_timer
// Brief  : Memory-mapped prescaled down-counter with one-shot/auto-reload,
//          sticky expiry flag and level interrupt.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_7F00,
    parameter int          PRESC_W   = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] memaddr,
    input  logic [31:0] memwritedata,
    output logic        hit,
    output logic [31:0] rdata,
    output logic        irq
);

    tmr_state_t         r_state;
    logic               r_ar;
    logic               r_ie;
    logic               r_exp;
    logic [31:0]        r_load;
    logic [31:0]        r_count;
    logic [PRESC_W-1:0] r_presc;

    logic               w_we;
    logic [2:0]         w_sel;
    logic               w_tick;
    logic               w_expire;
    logic               w_unused;

    assign hit      = (memaddr[31:5] == BASE_ADDR[31:5]);
    assign w_we     = memwrite && hit;
    assign w_sel    = memaddr[4:2];
    assign w_expire = w_tick && (r_count == 32'd0);
    assign irq      = r_exp && r_ie;
    assign w_unused = &{1'b0, memaddr[1:0]};

    timer_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_presc (
        .clk     (clk),
        .reset   (reset),
        .i_run   (r_state == ST_RUN),
        .i_clr   (w_we && (w_sel == TMR_CTRL)),
        .i_presc (r_presc),
        .o_tick  (w_tick)
    );

    // Tick effects are applied first so that same-edge register writes override them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_STOP;
            r_ar    <= 1'b0;
            r_ie    <= 1'b0;
            r_exp   <= 1'b0;
            r_load  <= 32'd0;
            r_count <= 32'd0;
            r_presc <= '0;
        end else begin
            if (w_tick) begin
                if (r_count != 32'd0) begin
                    r_count <= r_count - 32'd1;
                end else begin
                    r_exp <= 1'b1;
                    if (r_ar) begin
                        r_count <= r_load;
                    end else begin
                        r_state <= ST_STOP;
                    end
                end
            end
            if (w_we) begin
                case (w_sel)
                    TMR_CTRL: begin
                        r_state <= memwritedata[CTRL_EN] ? ST_RUN : ST_STOP;
                        r_ar    <= memwritedata[CTRL_AR];
                        r_ie    <= memwritedata[CTRL_IE];
                    end
                    TMR_LOAD:   r_load  <= memwritedata;
                    TMR_COUNT:  r_count <= memwritedata;
                    TMR_STATUS: begin
                        if (memwritedata[0] && !w_expire) begin
                            r_exp <= 1'b0;
                        end
                    end
                    TMR_PRESC:  r_presc <= memwritedata[PRESC_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (w_sel)
                TMR_CTRL:   rdata = {29'd0, r_ie, r_ar, (r_state == ST_RUN)};
                TMR_LOAD:   rdata = r_load;
                TMR_COUNT:  rdata = r_count;
                TMR_STATUS: rdata = {31'd0, r_exp};
                TMR_PRESC:  rdata = {{(32-PRESC_W){1'b0}}, r_presc};
                default:    rdata = 32'd0;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mmio_timer.sv
// ============================================================================
// Module : tb_mmio_timer
// Brief  : Self-checking bench for mmio_timer against a behavioural model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'hFFFF_7F00;
    localparam logic [31:0] O_CTRL = 32'h00, O_LOAD = 32'h04, O_COUNT = 32'h08,
                            O_STATUS = 32'h0C, O_PRESC = 32'h10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] memaddr = BASE;
    logic [31:0] memwritedata = 32'd0;
    logic        hit;
    logic        irq;
    logic [31:0] rdata;

    int n_chk = 0;
    int n_fail = 0;

    mmio_timer dut (
        .clk          (clk),
        .reset        (reset),
        .memwrite     (memwrite),
        .memaddr      (memaddr),
        .memwritedata (memwritedata),
        .hit          (hit),
        .rdata        (rdata),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Behavioural model of the programmer-visible timer state
    bit          m_run, m_ar, m_ie, m_exp;
    logic [31:0] m_load, m_count;
    int          m_presc, m_pcnt;

    function automatic void m_reset();
        m_run = 0; m_ar = 0; m_ie = 0; m_exp = 0;
        m_load = 0; m_count = 0; m_presc = 0; m_pcnt = 0;
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        return (a >= BASE) && (a - BASE < 32);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_hit(a)) return 0;
        case (a - BASE)
            O_CTRL:   return {29'd0, m_ie, m_ar, m_run};
            O_LOAD:   return m_load;
            O_COUNT:  return m_count;
            O_STATUS: return {31'd0, m_exp};
            O_PRESC:  return m_presc;
            default:  return 0;
        endcase
    endfunction

    function automatic bit m_tick_now();
        return m_run && (m_pcnt == m_presc);
    endfunction

    function automatic bit m_expiring();
        return m_tick_now() && (m_count == 0);
    endfunction

    function automatic void m_step(input bit we, input logic [31:0] a, input logic [31:0] d);
        bit          tick = m_tick_now();
        bit          expire = m_expiring();
        bit          w = we && m_hit(a);
        logic [31:0] off = a - BASE;
        logic [31:0] old_count = m_count;
        logic [31:0] old_load = m_load;
        m_pcnt = (!m_run) ? m_pcnt : (tick ? 0 : m_pcnt + 1);
        if (tick) begin
            if (old_count != 0) m_count = old_count - 1;
            else begin
                m_exp = 1;
                if (m_ar) m_count = old_load;
                else m_run = 0;
            end
        end
        if (w) begin
            case (off)
                O_CTRL:   begin m_run = d[0]; m_ar = d[1]; m_ie = d[2]; m_pcnt = 0; end
                O_LOAD:   m_load = d;
                O_COUNT:  m_count = d;
                O_STATUS: if (d[0] && !expire) m_exp = 0;
                O_PRESC:  m_presc = int'(d[15:0]);
                default:  ;
            endcase
        end
    endfunction

    // One bus cycle: outputs compared mid-cycle, model advanced at the edge
    task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] d);
        memwrite = we; memaddr = a; memwritedata = d;
        @(negedge clk);
        chk("hit", {31'd0, hit}, {31'd0, m_hit(a)});
        chk("rdata", rdata, m_read(a));
        chk("irq", {31'd0, irq}, {31'd0, (m_exp && m_ie)});
        @(posedge clk);
        m_step(we, a, d);
        #1;
        memwrite = 0;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        cyc(1, BASE + off, d);
    endtask

    task automatic idle(input logic [31:0] off);
        cyc(0, BASE + off, 32'd0);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        memwrite = 0; memaddr = a;
        #1;
        chk(tag, rdata, exp);
    endtask

    initial begin
        bit found;
        m_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        peek("rst_ctrl", BASE + O_CTRL, 0);
        peek("rst_count", BASE + O_COUNT, 0);
        chk("rst_irq", {31'd0, irq}, 0);
        reset = 1'b1;

        // One-shot countdown 3,2,1,0 then expiry
        wr(O_LOAD, 3); wr(O_COUNT, 3); wr(O_PRESC, 0); wr(O_CTRL, 1);
        peek("os_c3", BASE + O_COUNT, 3); idle(O_COUNT);
        peek("os_c2", BASE + O_COUNT, 2); idle(O_COUNT);
        peek("os_c1", BASE + O_COUNT, 1); idle(O_COUNT);
        peek("os_c0", BASE + O_COUNT, 0); idle(O_STATUS);
        peek("os_exp", BASE + O_STATUS, 1);
        peek("os_ctrl", BASE + O_CTRL, 0);
        peek("os_hold", BASE + O_COUNT, 0);
        repeat (3) idle(O_COUNT);

        // Auto-reload with IE: expiry period (2+1)*(1+1) = 6 cycles
        wr(O_STATUS, 1); wr(O_LOAD, 2); wr(O_COUNT, 2); wr(O_PRESC, 1); wr(O_CTRL, 7);
        repeat (5) idle(O_STATUS);
        peek("ar_noexp5", BASE + O_STATUS, 0);
        idle(O_STATUS);
        peek("ar_exp6", BASE + O_STATUS, 1);
        chk("ar_irq6", {31'd0, irq}, 1);
        wr(O_STATUS, 1);
        chk("ar_irq_clr", {31'd0, irq}, 0);
        wr(O_CTRL, 3);
        repeat (12) idle(O_STATUS);
        peek("ie0_exp", BASE + O_STATUS, 1);
        chk("ie0_irq", {31'd0, irq}, 0);

        // STATUS clear on an expiry edge: set wins
        wr(O_STATUS, 1);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_expiring()) begin wr(O_STATUS, 1); found = 1; end
            else idle(O_COUNT);
        end
        chk("clr_exp_found", {31'd0, found}, 1);
        peek("clr_exp_sticky", BASE + O_STATUS, 1);

        // COUNT write on a tick edge: write wins
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_tick_now() && m_count != 0) begin wr(O_COUNT, 9); found = 1; end
            else idle(O_COUNT);
        end
        chk("cnt_tick_found", {31'd0, found}, 1);
        peek("cnt_tick_wins", BASE + O_COUNT, 9);

        // Unmapped offset and out-of-window accesses
        wr(O_CTRL, 0);
        cyc(1, BASE + 32'h14, 32'hFFFF_FFFF);
        cyc(1, BASE + 32'h20, 32'hFFFF_FFFF);
        cyc(1, BASE - 32'h4, 32'hFFFF_FFFF);
        peek("unmap_rdata", BASE + 32'h14, 0);
        chk("unmap_hit", {31'd0, hit}, 1);
        peek("out_rdata", BASE + 32'h20, 0);
        chk("out_hit", {31'd0, hit}, 0);
        peek("unmap_load", BASE + O_LOAD, 2);
        for (int i = 0; i < 5; i++) idle(32'(i * 4));

        // LOAD write on a reload edge: old LOAD used, new LOAD next time
        wr(O_STATUS, 1); wr(O_PRESC, 0); wr(O_LOAD, 4); wr(O_COUNT, 0); wr(O_CTRL, 3);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_expiring()) begin wr(O_LOAD, 7); found = 1; end
            else idle(O_COUNT);
        end
        chk("rl_found", {31'd0, found}, 1);
        peek("rl_old", BASE + O_COUNT, 4);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (m_expiring()) found = 1;
            idle(O_COUNT);
        end
        chk("rl2_found", {31'd0, found}, 1);
        peek("rl_new", BASE + O_COUNT, 7);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            logic [31:0] a;
            logic [31:0] d;
            bit          we;
            int          r = $urandom_range(0, 19);
            if (r == 0)      a = BASE + 32'h20 + 4 * $urandom_range(0, 3);
            else if (r == 1) a = BASE - 32'h4;
            else             a = BASE + 4 * $urandom_range(0, 7);
            we = ($urandom_range(0, 3) == 0);
            case (a - BASE)
                O_CTRL:   d = ($urandom & 32'h6) | {31'd0, ($urandom_range(0, 4) != 0)};
                O_LOAD,
                O_COUNT:  d = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 6);
                O_PRESC:  d = $urandom_range(0, 3);
                default:  d = $urandom;
            endcase
            cyc(we, a, d);
        end

        // Asynchronous reset mid-run with irq asserted
        wr(O_PRESC, 0); wr(O_LOAD, 0); wr(O_CTRL, 7);
        repeat (2) idle(O_STATUS);
        wr(O_COUNT, 5);
        chk("pre_rst_irq", {31'd0, irq}, 1);
        reset = 1'b0;
        #1;
        chk("async_irq", {31'd0, irq}, 0);
        peek("async_count", BASE + O_COUNT, 0);
        peek("async_ctrl", BASE + O_CTRL, 0);
        m_reset();
        @(negedge clk);
        peek("async_status", BASE + O_STATUS, 0);
        peek("async_load", BASE + O_LOAD, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) idle(32'(i * 4));

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
